// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch/decode/exec/mem/wb over one memory port and one ALU.
// Latency: ALU/LUI/AUIPC/store 4, load 5, branch/JAL/JALR 3 cycles, plus one cycle per memory wait.
// Backpressure: FETCH and MEM hold their request steady until mem_ready; reset forces all outputs to 0.
module multicycle_ctrl #(
    parameter int K = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [6:0]   opcode,
    input  logic [2:0]   funct3,
    input  logic         funct7_5,
    input  logic         branch_taken,
    input  logic         mem_ready,
    output logic [K-1:0] imm_sel,
    output logic         ir_we,
    output logic         pc_we,
    output logic [1:0]   pc_src,
    output logic [1:0]   alu_src_a,
    output logic         alu_src_b,
    output logic [1:0]   alu_op,
    output logic         mem_req,
    output logic         mem_we,
    output logic         mem_addr_sel,
    output logic         reg_we,
    output logic [1:0]   wb_sel,
    output logic         illegal,
    output logic [2:0]   state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_AUI  = 7'b0010111;

    state_t     state_q;
    logic       illegal_q;
    logic       is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_aui;
    logic       dec_bad;
    logic [2:0] imm_dec;

    // Instruction class, legality and immediate format straight from the held IR fields.
    always_comb begin
        is_r    = 1'b0;
        is_i    = 1'b0;
        is_ld   = 1'b0;
        is_st   = 1'b0;
        is_br   = 1'b0;
        is_jal  = 1'b0;
        is_jalr = 1'b0;
        is_lui  = 1'b0;
        is_aui  = 1'b0;
        dec_bad = 1'b0;
        imm_dec = 3'b000;
        case (opcode)
            OP_R:    is_r = 1'b1;
            OP_I: begin
                is_i    = 1'b1;
                dec_bad = (funct3 == 3'b001) && funct7_5;
                if (funct3 == 3'b001 || funct3 == 3'b101) imm_dec = 3'b111;
            end
            OP_LD: begin
                is_ld   = 1'b1;
                dec_bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OP_ST: begin
                is_st   = 1'b1;
                dec_bad = (funct3 >= 3'b011);
                imm_dec = 3'b001;
            end
            OP_BR: begin
                is_br   = 1'b1;
                dec_bad = (funct3 == 3'b010) || (funct3 == 3'b011);
                imm_dec = 3'b010;
            end
            OP_JAL: begin
                is_jal  = 1'b1;
                imm_dec = 3'b100;
            end
            OP_JALR: is_jalr = 1'b1;
            OP_LUI: begin
                is_lui  = 1'b1;
                imm_dec = 3'b101;
            end
            OP_AUI: begin
                is_aui  = 1'b1;
                imm_dec = 3'b011;
            end
            default: dec_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH:  if (mem_ready) state_q <= S_DECODE;
                S_DECODE: begin
                    if (dec_bad) begin
                        illegal_q <= 1'b1;
                        state_q   <= S_HALT;
                    end else begin
                        state_q   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_ld || is_st)                       state_q <= S_MEM;
                    else if (is_r || is_i || is_lui || is_aui) state_q <= S_WB;
                    else                                      state_q <= S_FETCH;
                end
                S_MEM:    if (mem_ready) state_q <= is_ld ? S_WB : S_FETCH;
                S_WB:     state_q <= S_FETCH;
                S_HALT:   state_q <= S_HALT;
                default:  state_q <= S_FETCH;
            endcase
        end
    end

    // Outputs are a function of state and the held IR; reset masks everything so an aborted
    // instruction can never leak a pc_we/reg_we or a memory request.
    always_comb begin
        imm_sel      = '0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = 2'b00;
        alu_src_a    = 2'b00;
        alu_src_b    = 1'b0;
        alu_op       = 2'b00;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        reg_we       = 1'b0;
        wb_sel       = 2'b00;
        illegal      = illegal_q & ~rst;
        state        = rst ? 3'd0 : state_q;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    ir_we   = mem_ready;
                end
                S_DECODE: imm_sel = K'(imm_dec);
                S_EXEC: begin
                    imm_sel = K'(imm_dec);
                    if (is_r) begin
                        alu_op = 2'b01;
                    end else if (is_i) begin
                        alu_src_b = 1'b1;
                        alu_op    = 2'b01;
                    end else if (is_lui) begin
                        alu_src_a = 2'b10;
                        alu_src_b = 1'b1;
                    end else if (is_aui) begin
                        alu_src_a = 2'b01;
                        alu_src_b = 1'b1;
                    end else if (is_ld || is_st) begin
                        alu_src_b = 1'b1;
                    end else if (is_br) begin
                        alu_src_a = 2'b01;
                        alu_src_b = 1'b1;
                        pc_we     = 1'b1;
                        pc_src    = branch_taken ? 2'b01 : 2'b00;
                    end else if (is_jal) begin
                        alu_src_a = 2'b01;
                        alu_src_b = 1'b1;
                        pc_we     = 1'b1;
                        pc_src    = 2'b01;
                        reg_we    = 1'b1;
                        wb_sel    = 2'b10;
                    end else if (is_jalr) begin
                        alu_src_b = 1'b1;
                        pc_we     = 1'b1;
                        pc_src    = 2'b10;
                        reg_we    = 1'b1;
                        wb_sel    = 2'b10;
                    end
                end
                S_MEM: begin
                    imm_sel      = K'(imm_dec);
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = is_st;
                    pc_we        = is_st & mem_ready;
                end
                S_WB: begin
                    imm_sel = K'(imm_dec);
                    reg_we  = 1'b1;
                    wb_sel  = is_ld ? 2'b01 : 2'b00;
                    pc_we   = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: decode/latency table, per-cycle reference model on random
// instruction streams with random memory waits, and reset-abort sequences.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       funct7_5 = 1'b0;
    logic       branch_taken = 1'b0;
    logic       mem_ready = 1'b0;
    logic [2:0] imm_sel;
    logic       ir_we, pc_we, alu_src_b, mem_req, mem_we, mem_addr_sel, reg_we, illegal;
    logic [1:0] pc_src, alu_src_a, alu_op, wb_sel;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.K(3)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .branch_taken(branch_taken), .mem_ready(mem_ready), .imm_sel(imm_sel),
        .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr_sel(mem_addr_sel), .reg_we(reg_we), .wb_sel(wb_sel),
        .illegal(illegal), .state(state)
    );

    typedef struct packed {
        logic [2:0] imm_sel;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic [1:0] a;
        logic       b;
        logic [1:0] alu_op;
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       reg_we;
        logic [1:0] wb_sel;
        logic       illegal;
        logic [2:0] state;
    } ctrl_t;

    localparam int C_ILL = 0, C_R = 1, C_I = 2, C_LD = 3, C_ST = 4, C_BR = 5,
                   C_JAL = 6, C_JALR = 7, C_LUI = 8, C_AUI = 9;
    localparam int P_F = 0, P_D = 1, P_E = 2, P_M = 3, P_W = 4, P_H = 5;

    typedef struct {
        logic [31:0] ir;
        bit          bt;
        logic [2:0]  imm;
        int          len;
        bit          ill;
    } vec_t;

    vec_t tbl[19];

    function automatic ctrl_t dut_vec();
        return {imm_sel, ir_we, pc_we, pc_src, alu_src_a, alu_src_b, alu_op,
                mem_req, mem_we, mem_addr_sel, reg_we, wb_sel, illegal, state};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int classify(input logic [31:0] ir);
        logic [2:0] f3;
        f3 = ir[14:12];
        case (ir[6:0])
            7'b0110011: return C_R;
            7'b0010011: return (f3 == 3'd1 && ir[30]) ? C_ILL : C_I;
            7'b0000011: return (f3 inside {3'd3, 3'd6, 3'd7}) ? C_ILL : C_LD;
            7'b0100011: return (f3 > 3'd2) ? C_ILL : C_ST;
            7'b1100011: return (f3 inside {3'd2, 3'd3}) ? C_ILL : C_BR;
            7'b1101111: return C_JAL;
            7'b1100111: return C_JALR;
            7'b0110111: return C_LUI;
            7'b0010111: return C_AUI;
            default:    return C_ILL;
        endcase
    endfunction

    function automatic logic [2:0] imm_of(input logic [31:0] ir);
        case (ir[6:0])
            7'b0010011: return (ir[14:12] == 3'd1 || ir[14:12] == 3'd5) ? 3'b111 : 3'b000;
            7'b0100011: return 3'b001;
            7'b1100011: return 3'b010;
            7'b0010111: return 3'b011;
            7'b1101111: return 3'b100;
            7'b0110111: return 3'b101;
            default:    return 3'b000;
        endcase
    endfunction

    // Expected outputs for one cycle of an instruction in a given phase.
    function automatic ctrl_t model(input int ph, input logic [31:0] ir, input bit bt, input bit mr);
        ctrl_t c;
        int    cls;
        c     = '0;
        cls   = classify(ir);
        c.state = 3'(ph);
        if (ph >= P_D && ph <= P_W) c.imm_sel = imm_of(ir);
        case (ph)
            P_F: begin c.mem_req = 1'b1; c.ir_we = mr; end
            P_E: begin
                case (cls)
                    C_R:   c.alu_op = 2'b01;
                    C_I:   begin c.b = 1'b1; c.alu_op = 2'b01; end
                    C_LUI: begin c.a = 2'b10; c.b = 1'b1; end
                    C_AUI: begin c.a = 2'b01; c.b = 1'b1; end
                    C_LD, C_ST: c.b = 1'b1;
                    C_BR:  begin c.a = 2'b01; c.b = 1'b1; c.pc_we = 1'b1; c.pc_src = bt ? 2'b01 : 2'b00; end
                    C_JAL: begin c.a = 2'b01; c.b = 1'b1; c.pc_we = 1'b1; c.pc_src = 2'b01;
                                 c.reg_we = 1'b1; c.wb_sel = 2'b10; end
                    C_JALR: begin c.b = 1'b1; c.pc_we = 1'b1; c.pc_src = 2'b10;
                                  c.reg_we = 1'b1; c.wb_sel = 2'b10; end
                    default: ;
                endcase
            end
            P_M: begin
                c.mem_req = 1'b1; c.mem_addr_sel = 1'b1;
                c.mem_we  = (cls == C_ST);
                c.pc_we   = (cls == C_ST) && mr;
            end
            P_W: begin c.reg_we = 1'b1; c.wb_sel = (cls == C_LD) ? 2'b01 : 2'b00; c.pc_we = 1'b1; end
            P_H: c.illegal = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    task automatic set_ir(input logic [31:0] ir);
        opcode   = ir[6:0];
        funct3   = ir[14:12];
        funct7_5 = ir[30];
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        check("reset_outputs", 32'(dut_vec()), 32'd0);
        rst = 1'b0;
    endtask

    // Runs one instruction as a phase plan derived from the latency rules; abort >= 0 stops
    // before that plan entry (at posedge+1) so the caller can assert reset mid-instruction.
    task automatic run_instr(input logic [31:0] ir, input bit bt, input int wf, input int wm,
                             input int abort, output int n_busy, output int n_mem);
        int ph_q[$];
        bit mr_q[$];
        int cls;
        cls    = classify(ir);
        n_busy = 0;
        n_mem  = 0;
        set_ir(ir);
        repeat (wf) begin ph_q.push_back(P_F); mr_q.push_back(1'b0); end
        ph_q.push_back(P_F); mr_q.push_back(1'b1);
        ph_q.push_back(P_D); mr_q.push_back(1'($urandom_range(0, 1)));
        if (cls == C_ILL) begin
            repeat (10) begin ph_q.push_back(P_H); mr_q.push_back(1'($urandom_range(0, 1))); end
        end else begin
            ph_q.push_back(P_E); mr_q.push_back(1'($urandom_range(0, 1)));
            if (cls == C_LD || cls == C_ST) begin
                repeat (wm) begin ph_q.push_back(P_M); mr_q.push_back(1'b0); end
                ph_q.push_back(P_M); mr_q.push_back(1'b1);
            end
            if (cls inside {C_R, C_I, C_LUI, C_AUI, C_LD}) begin
                ph_q.push_back(P_W); mr_q.push_back(1'($urandom_range(0, 1)));
            end
        end
        for (int i = 0; i < ph_q.size(); i++) begin
            if (abort >= 0 && i == abort) return;
            mem_ready    = mr_q[i];
            branch_taken = (ph_q[i] == P_E) ? bt : 1'($urandom_range(0, 1));
            @(negedge clk);
            check("cycle", 32'(dut_vec()), 32'(model(ph_q[i], ir, bt, mr_q[i])));
            if (state != 3'd0) n_busy++;
            if (state == 3'd3) n_mem++;
            @(posedge clk); #1;
        end
    endtask

    // Zero-wait run, measuring length and DECODE-cycle imm_sel purely from DUT state.
    task automatic table_run(input logic [31:0] ir, input bit bt, output int len,
                             output logic [2:0] dimm, output logic ill);
        set_ir(ir);
        branch_taken = bt;
        mem_ready    = 1'b1;
        len  = 0;
        dimm = 3'bxxx;
        ill  = 1'bx;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (state == 3'd1) dimm = imm_sel;
            if (n > 0 && (state == 3'd0 || state == 3'd5)) begin
                ill = illegal;
                break;
            end
            len++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int         len, n_busy, n_mem;
        logic [2:0] dimm;
        logic       ill;

        tbl[0]  = '{32'h00500093, 1'b0, 3'b000, 4, 1'b0};
        tbl[1]  = '{32'h0080A103, 1'b0, 3'b000, 5, 1'b0};
        tbl[2]  = '{32'h00000463, 1'b1, 3'b010, 3, 1'b0};
        tbl[3]  = '{32'h00000463, 1'b0, 3'b010, 3, 1'b0};
        tbl[4]  = '{32'h00419193, 1'b0, 3'b111, 4, 1'b0};
        tbl[5]  = '{32'h000280E7, 1'b0, 3'b000, 3, 1'b0};
        tbl[6]  = '{32'h0020A023, 1'b0, 3'b001, 4, 1'b0};
        tbl[7]  = '{32'h008000EF, 1'b0, 3'b100, 3, 1'b0};
        tbl[8]  = '{32'h123450B7, 1'b0, 3'b101, 4, 1'b0};
        tbl[9]  = '{32'h00001097, 1'b0, 3'b011, 4, 1'b0};
        tbl[10] = '{32'h002081B3, 1'b0, 3'b000, 4, 1'b0};
        tbl[11] = '{32'h4041D193, 1'b0, 3'b111, 4, 1'b0};
        tbl[12] = '{32'h40419193, 1'b0, 3'b111, 2, 1'b1};
        tbl[13] = '{32'h0000B003, 1'b0, 3'b000, 2, 1'b1};
        tbl[14] = '{32'h0000B023, 1'b0, 3'b001, 2, 1'b1};
        tbl[15] = '{32'h00002063, 1'b0, 3'b010, 2, 1'b1};
        tbl[16] = '{32'h0000007F, 1'b0, 3'b000, 2, 1'b1};
        tbl[17] = '{32'h0000D003, 1'b0, 3'b000, 5, 1'b0};
        tbl[18] = '{32'h00007063, 1'b1, 3'b010, 3, 1'b0};

        for (int i = 0; i < 19; i++) begin
            do_reset();
            table_run(tbl[i].ir, tbl[i].bt, len, dimm, ill);
            check($sformatf("tbl%0d_len", i), 32'(len), 32'(tbl[i].len));
            check($sformatf("tbl%0d_imm", i), 32'(dimm), 32'(tbl[i].imm));
            check($sformatf("tbl%0d_ill", i), 32'(ill), 32'(tbl[i].ill));
        end

        // Load with two MEM wait cycles: MEM lasts 3 cycles, 7 cycles overall.
        do_reset();
        run_instr(32'h0080A103, 1'b0, 0, 2, -1, n_busy, n_mem);
        check("lw_mem_cycles", 32'(n_mem), 32'd3);
        check("lw_total", 32'(n_busy + 1), 32'd7);

        // JALR followed by a zero-wait store.
        run_instr(32'h000280E7, 1'b0, 0, 0, -1, n_busy, n_mem);
        check("jalr_total", 32'(n_busy + 1), 32'd3);
        run_instr(32'h0020A023, 1'b0, 0, 0, -1, n_busy, n_mem);
        check("sw_total", 32'(n_busy + 1), 32'd4);

        // Illegal SLLI: halts and stays halted.
        run_instr(32'h40419193, 1'b0, 0, 0, -1, n_busy, n_mem);

        // Reset during a FETCH wait.
        do_reset();
        run_instr(32'h00500093, 1'b0, 3, 0, 2, n_busy, n_mem);
        mem_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_fetch_comb", 32'(dut_vec()), 32'd0);
        @(posedge clk); #1;
        check("rst_fetch_next", 32'(dut_vec()), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_fetch_req", 32'({mem_req, mem_addr_sel, state, pc_we}), 32'b1_0_000_0);
        run_instr(32'h00500093, 1'b0, 0, 0, -1, n_busy, n_mem);

        // Reset during a MEM wait of a load drops the request.
        run_instr(32'h0080A103, 1'b0, 0, 3, 4, n_busy, n_mem);
        rst = 1'b1;
        #1;
        check("rst_mem_comb", 32'(dut_vec()), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_instr(32'h002081B3, 1'b0, 0, 0, -1, n_busy, n_mem);

        // Random instruction stream with random waits, checked cycle by cycle.
        for (int k = 0; k < 80; k++) begin
            int idx;
            idx = $urandom_range(0, 18);
            run_instr(tbl[idx].ir, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                      $urandom_range(0, 3), -1, n_busy, n_mem);
            if (classify(tbl[idx].ir) == C_ILL) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control FSM for the RV32I core. Sequences fetch, decode, execute, memory and writeback over a shared single-port memory and a single ALU. Drives the immediate generator's `imm_sel` and all datapath enables and muxes. Holds the instruction register contents stable for the whole instruction, and halts on any unsupported encoding.

## Interface
Parameters:
- `K`, 3, width of `imm_sel`; must match the immediate generator.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous and active-high
- `opcode`  in  7  IR[6:0]
- `funct3`  in  3  IR[14:12]
- `funct7_5`  in  1  IR[30]
- `branch_taken`  in  1  branch comparator result for current IR; valid in EXEC
- `mem_ready`  in  1  memory completes access this cycle; sampled only while `mem_req`=1
- `imm_sel`  out  K  000 I, 111 shift-imm, 001 S, 010 B, 011 AUIPC, 100 J, 101 LUI
- `ir_we`  out  1  load IR from memory read data
- `pc_we`  out  1  load PC
- `pc_src`  out  2  00 PC+4, 01 ALU result, 10 ALU result & ~1
- `alu_src_a`  out  2  00 rs1, 01 PC, 10 zero
- `alu_src_b`  out  1  0 rs2, 1 immediate
- `alu_op`  out  2  00 add, 01 decode funct3/funct7, 10 reserved (branch compare is external)
- `mem_req`  out  1  memory access request
- `mem_we`  out  1  store (valid with `mem_req`)
- `mem_addr_sel`  out  1  0 PC, 1 ALUOut register
- `reg_we`  out  1  register-file write
- `wb_sel`  out  2  00 ALUOut, 01 memory data, 10 PC+4
- `illegal`  out  1  sticky; set on unsupported encoding
- `state`  out  3  current state (debug)

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Codes 6–7 go to FETCH.
- Every control output not listed for a state is 0.
- `imm_sel` is decoded combinationally from `opcode`/`funct3` in DECODE, EXEC, MEM and WB. It is 000 in FETCH and HALT.
- Shift-immediate selection: opcode 0010011 with funct3 001 or 101 selects 111.
- FETCH: `mem_req`=1, `mem_addr_sel`=0. Wait while `mem_ready`=0. When `mem_ready`=1, assert `ir_we` and go to DECODE.
- DECODE: register-file read. Supported opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
- DECODE illegal cases:
  - any other opcode;
  - SLLI with `funct7_5`=1;
  - load funct3 ∈ {011, 110, 111};
  - store funct3 ≥ 011;
  - branch funct3 ∈ {010, 011}.
  - On any of these, set `illegal` and go to HALT. Otherwise go to EXEC.
- EXEC by class:
  - R-type: a=00, b=0, `alu_op`=01; go to WB.
  - I-ALU: a=00, b=1, `alu_op`=01; go to WB.
  - LUI: a=10, b=1, `alu_op`=00; go to WB.
  - AUIPC: a=01, b=1, `alu_op`=00; go to WB.
  - Load/store: a=00, b=1, `alu_op`=00 (address into ALUOut); go to MEM.
  - Branch: a=01, b=1 (target PC+imm); `pc_we`=1, `pc_src`=01 if `branch_taken` else 00; go to FETCH.
  - JAL: a=01, b=1, `pc_we`=1, `pc_src`=01, `reg_we`=1, `wb_sel`=10; go to FETCH.
  - JALR: a=00, b=1, `pc_we`=1, `pc_src`=10, `reg_we`=1, `wb_sel`=10; go to FETCH.
- MEM: `mem_req`=1, `mem_addr_sel`=1, `mem_we`=1 for stores. Hold while `mem_ready`=0.
  - Load completes: go to WB.
  - Store completes: `pc_we`=1, `pc_src`=00; go to FETCH.
- WB: `reg_we`=1, `wb_sel`=01 for loads else 00, `pc_we`=1, `pc_src`=00; go to FETCH.
- HALT: absorbing. All enables 0 and `illegal`=1 until reset.
- `mem_req`, `mem_we`, `mem_addr_sel` stay constant from request until `mem_ready`.

## Timing
- Reset: on a rising edge with `rst`=1, state becomes FETCH and `illegal` becomes 0.
- While `rst`=1, all outputs are forced to 0 combinationally, including `mem_req` and `state`.
- First request is in the first cycle after `rst` falls.
- Latency with zero-wait memory (`mem_ready`=1 on first request cycle):
  - ALU/LUI/AUIPC 4 cycles;
  - load 5;
  - store 4;
  - branch/JAL/JALR 3.
- Each wait cycle adds 1.
- Exactly one `pc_we` pulse per retired instruction, in its final cycle. That cycle is also the only `reg_we` pulse for that instruction.
- `ir_we` is asserted only in the FETCH cycle where `mem_ready`=1.
- Reset mid-instruction, including during a memory wait, aborts the instruction. No `pc_we`/`reg_we` is issued, and the pending request is dropped.
- `mem_ready`=1 while `mem_req`=0 is ignored.

## Test plan
- Reset, then `addi x1,x0,5` (0x00500093) with zero-wait memory:
  - states 0,1,2,4 then back to 0;
  - `imm_sel`=000, `reg_we`=1, `wb_sel`=00 only in the WB cycle;
  - one `pc_we` pulse with `pc_src`=00.
- `lw x2,8(x1)` (0x0080A103) with `mem_ready` low for 2 cycles in MEM:
  - MEM lasts 3 cycles with `mem_addr_sel`=1, `mem_we`=0;
  - then WB with `wb_sel`=01; 7 cycles total.
- `beq x0,x0,+8` (0x00000463) with `branch_taken`=1: EXEC gives `imm_sel`=010, `pc_src`=01, `pc_we`=1; return to FETCH after 3 cycles. Repeat with `branch_taken`=0: `pc_src`=00.
- `slli x3,x3,4` (0x00419193): `imm_sel`=111. Same instruction with IR[30]=1 (0x40419193): DECODE sets `illegal`=1 and state=5; state stays 5 for 10 cycles with all enables 0.
- `jalr x1,0(x5)` (0x000280E7):
  - EXEC asserts `pc_src`=10, `reg_we`=1, `wb_sel`=10 and `pc_we` in the same cycle.
  - Then `sw` (0x0020A023) completes in 4 cycles with `mem_we`=1 and no `reg_we`.
- Assert `rst` during a FETCH wait (`mem_ready`=0):
  - next cycle all outputs are 0 and state=0;
  - after `rst` falls, `mem_req`=1, `mem_addr_sel`=0;
  - no `pc_we` is observed across the reset.
